// File: rtl/serial_full_adder.sv
// Bit-serial adder: one full-adder cell walks the operands LSB first and keeps
// the ripple carry in a register between cycles.

module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic ci_i,
   output logic s_o,
   output logic co_o
);
   assign s_o  = a_i ^ b_i ^ ci_i;
   assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module serial_full_adder #(
   parameter int Width = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [Width-1:0] a_i,
   input  logic [Width-1:0] b_i,
   input  logic             ci_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [Width-1:0] sum_o,
   output logic             co_o
);
   localparam int CntW = (Width > 1) ? $clog2(Width) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [Width-1:0]  a_q, a_d;
   logic [Width-1:0]  b_q, b_d;
   logic [Width-1:0]  sum_q, sum_d;
   logic              carry_q, carry_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              fa_s;
   logic              fa_co;

   full_adder u_full_adder (
      .a_i  (a_q[0]),
      .b_i  (b_q[0]),
      .ci_i (carry_q),
      .s_o  (fa_s),
      .co_o (fa_co)
   );

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; ready/valid here decode state only, and data is held while valid.
   assign in_ready_o  = (state_q == ST_IDLE);
   assign out_valid_o = (state_q == ST_DONE);
   assign sum_o       = sum_q;
   assign co_o        = carry_q;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid_i) begin
               a_d     = a_i;
               b_d     = b_i;
               carry_d = ci_i;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // New sum bit enters at the MSB so bit 0 lands at position 0 last.
            sum_d            = sum_q >> 1;
            sum_d[Width-1]   = fa_s;
            a_d              = a_q >> 1;
            b_d              = b_q >> 1;
            carry_d          = fa_co;
            cnt_d            = cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_serial_full_adder.sv
// Bench for serial_full_adder at Width 8, 1 and 16 against plain-arithmetic sums.

module tb_serial_full_adder;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Width 8 instance
   logic       in_valid_8 = 0, in_ready_8, ci_8 = 0, out_valid_8, out_ready_8 = 0, co_8;
   logic [7:0] a_8 = '0, b_8 = '0, sum_8;
   // Width 1 instance
   logic       in_valid_1 = 0, in_ready_1, ci_1 = 0, out_valid_1, out_ready_1 = 0, co_1;
   logic [0:0] a_1 = '0, b_1 = '0, sum_1;
   // Width 16 instance
   logic        in_valid_16 = 0, in_ready_16, ci_16 = 0, out_valid_16, out_ready_16 = 0, co_16;
   logic [15:0] a_16 = '0, b_16 = '0, sum_16;

   logic [16:0] exp_q[$];

   serial_full_adder #(.Width(8)) dut8 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid_8), .in_ready_o(in_ready_8),
      .a_i(a_8), .b_i(b_8), .ci_i(ci_8), .out_valid_o(out_valid_8),
      .out_ready_i(out_ready_8), .sum_o(sum_8), .co_o(co_8));

   serial_full_adder #(.Width(1)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid_1), .in_ready_o(in_ready_1),
      .a_i(a_1), .b_i(b_1), .ci_i(ci_1), .out_valid_o(out_valid_1),
      .out_ready_i(out_ready_1), .sum_o(sum_1), .co_o(co_1));

   serial_full_adder #(.Width(16)) dut16 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid_16), .in_ready_o(in_ready_16),
      .a_i(a_16), .b_i(b_16), .ci_i(ci_16), .out_valid_o(out_valid_16),
      .out_ready_i(out_ready_16), .sum_o(sum_16), .co_o(co_16));

   // Driver: offer one operand set at a negedge, return edges until out_valid.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci, output int lat);
      @(negedge clk);
      a_8 = a; b_8 = b; ci_8 = ci; in_valid_8 = 1'b1; out_ready_8 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid_8 = 1'b0;
      lat = 0;
      while (!out_valid_8 && lat < 64) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic release8();
      out_ready_8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready_8 = 1'b0;
   endtask

   task automatic run1(input logic a, input logic b, input logic ci, output int lat);
      @(negedge clk);
      a_1 = a; b_1 = b; ci_1 = ci; in_valid_1 = 1'b1; out_ready_1 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid_1 = 1'b0;
      lat = 0;
      while (!out_valid_1 && lat < 16) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      int lat;
      #1 rst_n = 1'b0;
      #2;
      n_checks++;
      if ({in_ready_8, out_valid_8, sum_8, co_8} !== {1'b1, 1'b0, 8'h00, 1'b0})
         $display("FAIL reset_por8: got rdy=%b vld=%b sum=%h co=%b want 1 0 00 0",
                  in_ready_8, out_valid_8, sum_8, co_8);
      else n_pass++;
      n_checks++;
      if ({in_ready_16, out_valid_16, sum_16, co_16, in_ready_1, out_valid_1, sum_1, co_1}
          !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0})
         $display("FAIL reset_por16_1: got rdy16=%b vld16=%b sum16=%h rdy1=%b vld1=%b want idle zeros",
                  in_ready_16, out_valid_16, sum_16, in_ready_1, out_valid_1);
      else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      // 0xC3 + 0x4E + 1 = 0x112: leaves nonzero sum and carry in DONE
      run8(8'hC3, 8'h4E, 1'b1, lat);
      n_checks++;
      if ({out_valid_8, sum_8, co_8} !== {1'b1, 8'h12, 1'b1})
         $display("FAIL reset_preload: got vld=%b sum=%h co=%b want 1 12 1", out_valid_8, sum_8, co_8);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({in_ready_8, out_valid_8, sum_8, co_8} !== {1'b1, 1'b0, 8'h00, 1'b0})
         $display("FAIL reset_async: got rdy=%b vld=%b sum=%h co=%b want 1 0 00 0",
                  in_ready_8, out_valid_8, sum_8, co_8);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int lat;
      run8(8'h5A, 8'h33, 1'b0, lat);
      n_checks++;
      if (lat !== 8) $display("FAIL basic_latency: got %0d edges want 8", lat);
      else n_pass++;
      n_checks++;
      if ({out_valid_8, in_ready_8, sum_8, co_8} !== {1'b1, 1'b0, 8'h8D, 1'b0})
         $display("FAIL basic_result: got vld=%b rdy=%b sum=%h co=%b want 1 0 8d 0",
                  out_valid_8, in_ready_8, sum_8, co_8);
      else n_pass++;
      release8();
      n_checks++;
      if ({in_ready_8, out_valid_8, sum_8, co_8} !== {1'b1, 1'b0, 8'h8D, 1'b0})
         $display("FAIL basic_hold_idle: got rdy=%b vld=%b sum=%h co=%b want 1 0 8d 0",
                  in_ready_8, out_valid_8, sum_8, co_8);
      else n_pass++;
   endtask

   task automatic test_carry();
      logic [7:0] ta[2], tb[2], ts[2];
      logic       tc[2], tco[2];
      int lat;
      ta[0] = 8'hFF; tb[0] = 8'h01; tc[0] = 1'b0; ts[0] = 8'h00; tco[0] = 1'b1;
      ta[1] = 8'hFF; tb[1] = 8'hFF; tc[1] = 1'b1; ts[1] = 8'hFF; tco[1] = 1'b1;
      for (int i = 0; i < 2; i++) begin
         run8(ta[i], tb[i], tc[i], lat);
         n_checks++;
         if ({lat == 8, sum_8, co_8} !== {1'b1, ts[i], tco[i]})
            $display("FAIL carry_%0d: got lat=%0d sum=%h co=%b want lat=8 sum=%h co=%b",
                     i, lat, sum_8, co_8, ts[i], tco[i]);
         else n_pass++;
         release8();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      run8(8'h12, 8'h34, 1'b1, lat);
      for (int i = 0; i < 5; i++) begin
         in_valid_8 = i[0];
         a_8 = 8'($urandom);
         b_8 = 8'($urandom);
         ci_8 = 1'($urandom_range(0, 1));
         n_checks++;
         if ({out_valid_8, in_ready_8, sum_8, co_8} !== {1'b1, 1'b0, 8'h47, 1'b0})
            $display("FAIL bp_stall_%0d: got vld=%b rdy=%b sum=%h co=%b want 1 0 47 0",
                     i, out_valid_8, in_ready_8, sum_8, co_8);
         else n_pass++;
         @(posedge clk);
         @(negedge clk);
      end
      // Offer operands on the same edge the result is taken: must not be captured.
      a_8 = 8'hFF; b_8 = 8'hFF; ci_8 = 1'b1; in_valid_8 = 1'b1;
      release8();
      in_valid_8 = 1'b0;
      n_checks++;
      if ({in_ready_8, out_valid_8, sum_8, co_8} !== {1'b1, 1'b0, 8'h47, 1'b0})
         $display("FAIL bp_release: got rdy=%b vld=%b sum=%h co=%b want 1 0 47 0",
                  in_ready_8, out_valid_8, sum_8, co_8);
      else n_pass++;
      run8(8'h01, 8'h02, 1'b0, lat);
      n_checks++;
      if ({lat == 8, sum_8, co_8} !== {1'b1, 8'h03, 1'b0})
         $display("FAIL bp_next_op: got lat=%0d sum=%h co=%b want lat=8 sum=03 co=0", lat, sum_8, co_8);
      else n_pass++;
      release8();
   endtask

   task automatic test_reset_mid();
      int lat;
      int seen;
      @(negedge clk);
      a_8 = 8'h5A; b_8 = 8'h33; ci_8 = 1'b0; in_valid_8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid_8 = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({in_ready_8, out_valid_8, sum_8, co_8} !== {1'b1, 1'b0, 8'h00, 1'b0})
         $display("FAIL midrst_state: got rdy=%b vld=%b sum=%h co=%b want 1 0 00 0",
                  in_ready_8, out_valid_8, sum_8, co_8);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid_8) seen++;
      end
      n_checks++;
      if (seen !== 0) $display("FAIL midrst_no_result: got %0d valid cycles want 0", seen);
      else n_pass++;
      run8(8'h10, 8'h20, 1'b1, lat);
      n_checks++;
      if ({lat == 8, sum_8, co_8} !== {1'b1, 8'h31, 1'b0})
         $display("FAIL midrst_next_op: got lat=%0d sum=%h co=%b want lat=8 sum=31 co=0", lat, sum_8, co_8);
      else n_pass++;
      release8();
   endtask

   task automatic test_width1();
      int lat;
      int total;
      for (int k = 7; k >= 0; k--) begin
         run1(k[2], k[1], k[0], lat);
         total = int'(k[2]) + int'(k[1]) + int'(k[0]);
         n_checks++;
         if (lat !== 1 || sum_1 !== 1'(total % 2) || co_1 !== 1'(total / 2))
            $display("FAIL w1_%0d%0d%0d: got lat=%0d sum=%b co=%b want lat=1 sum=%0d co=%0d",
                     k[2], k[1], k[0], lat, sum_1, co_1, total % 2, total / 2);
         else n_pass++;
         out_ready_1 = 1'b1;
         @(posedge clk);
         @(negedge clk);
         out_ready_1 = 1'b0;
      end
   endtask

   task automatic test_random16();
      int sent = 0, got = 0, cyc = 0;
      logic        stalled = 1'b0;
      logic [16:0] held = '0;
      logic [16:0] exp_v;
      exp_q.delete();
      @(negedge clk);
      while (got < 1000 && cyc < 60000) begin
         if (stalled) begin
            n_checks++;
            if (!out_valid_16 || {co_16, sum_16} !== held)
               $display("FAIL rnd_hold: got vld=%b res=%h want 1 %h", out_valid_16, {co_16, sum_16}, held);
            else n_pass++;
         end
         in_valid_16  = (sent < 1000) && ($urandom_range(0, 3) != 0);
         a_16         = 16'($urandom);
         b_16         = 16'($urandom);
         ci_16        = 1'($urandom_range(0, 1));
         out_ready_16 = ($urandom_range(0, 1) == 1);
         if (in_valid_16 && in_ready_16) begin
            exp_q.push_back({1'b0, a_16} + {1'b0, b_16} + {16'b0, ci_16});
            sent++;
         end
         if (out_valid_16 && out_ready_16) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL rnd_unexpected: result %h with empty queue", {co_16, sum_16});
            end else begin
               exp_v = exp_q.pop_front();
               if ({co_16, sum_16} !== exp_v)
                  $display("FAIL rnd_result_%0d: got %h want %h", got, {co_16, sum_16}, exp_v);
               else n_pass++;
            end
            got++;
         end
         stalled = out_valid_16 && !out_ready_16;
         held    = {co_16, sum_16};
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      in_valid_16 = 1'b0;
      out_ready_16 = 1'b0;
      n_checks++;
      if (got !== 1000 || exp_q.size() !== 0)
         $display("FAIL rnd_complete: got %0d results, %0d pending, want 1000 and 0", got, exp_q.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_backpressure();
      test_reset_mid();
      test_width1();
      test_random16();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
